xy_router_rr: RTL and testbench

//  5-port XY mesh router for the NoC: per-input FIFO, deterministic XY route, per-output

---
 rtl/xy_router_rr_if.sv | 24 ++
 rtl/xy_router_rr.sv | 145 ++++++++++++++
 tb/tb_xy_router_rr.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_router_rr_if.sv
// Packet-side bundle of the XY router: input write strobes/packets, downstream full flags,
// and the registered output strobes/packets.
interface xy_router_rr_if #(
    parameter int PORT_N = 5,
    parameter int PCKT_W = 16
);
    logic [PORT_N-1:0]        wr_en_sw_i;
    logic [PCKT_W*PORT_N-1:0] pckt_sw_i;
    logic [PORT_N-1:0]        in_fifo_full_o;
    logic [PORT_N-1:0]        in_fifo_overflow_o;
    logic [PORT_N-1:0]        nxt_fifo_full_i;
    logic [PORT_N-1:0]        wr_en_sw_o;
    logic [PCKT_W*PORT_N-1:0] pckt_sw_o;

    modport master (
        output wr_en_sw_i, pckt_sw_i, nxt_fifo_full_i,
        input  in_fifo_full_o, in_fifo_overflow_o, wr_en_sw_o, pckt_sw_o
    );

    modport slave (
        input  wr_en_sw_i, pckt_sw_i, nxt_fifo_full_i,
        output in_fifo_full_o, in_fifo_overflow_o, wr_en_sw_o, pckt_sw_o
    );
endinterface

// File: rtl/xy_router_rr.sv
// 5-port XY mesh router: per-input FIFO, dimension-ordered route (X first),
// per-output round-robin arbitration gated by downstream full, registered outputs.
module xy_router_rr #(
    parameter int COL_CORD        = 0,
    parameter int ROW_CORD        = 0,
    parameter int PORT_N          = 5,
    parameter int IN_FIFO_DEPTH_W = 3,
    parameter int PCKT_COL_ADDR_W = 4,
    parameter int PCKT_ROW_ADDR_W = 4,
    parameter int PCKT_DATA_W     = 8,
    parameter int PCKT_W          = PCKT_COL_ADDR_W + PCKT_ROW_ADDR_W + PCKT_DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    xy_router_rr_if.slave bus
);
    localparam int DEPTH = 1 << IN_FIFO_DEPTH_W;
    localparam int CNT_W = IN_FIFO_DEPTH_W + 1;
    localparam int IDX_W = $clog2(PORT_N);
    localparam int P_RES = 0;
    localparam int P_NTH = 1;
    localparam int P_EST = 2;
    localparam int P_STH = 3;
    localparam int P_WST = 4;

    logic [PCKT_W-1:0] head       [PORT_N];
    logic [PORT_N-1:0] req        [PORT_N];  // req[input][output]
    logic [IDX_W-1:0]  rr_ptr     [PORT_N];
    logic [IDX_W-1:0]  grant_idx  [PORT_N];
    logic [PCKT_W-1:0] grant_pckt [PORT_N];
    logic [PORT_N-1:0] grant_vld;
    logic [PORT_N-1:0] pop;
    logic [PORT_N-1:0] full;
    logic [PORT_N-1:0] ovf;
    logic [IDX_W-1:0]  cand_idx;
    int                cand;

    genvar gi;
    generate
        for (gi = 0; gi < PORT_N; gi++) begin : g_in
            logic [PCKT_W-1:0]          mem_q [DEPTH];
            logic [IN_FIFO_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
            logic [CNT_W-1:0]           cnt_q, cnt_d;
            logic                       ovf_q;
            logic                       push;
            logic [PORT_N-1:0]          route;
            logic [PCKT_COL_ADDR_W-1:0] dst_col;
            logic [PCKT_ROW_ADDR_W-1:0] dst_row;

            assign full[gi]  = (cnt_q == CNT_W'(DEPTH));
            assign push      = bus.wr_en_sw_i[gi] && !full[gi];
            assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop[gi]);
            assign head[gi]  = mem_q[rd_ptr_q];
            assign dst_col   = head[gi][PCKT_W-1 -: PCKT_COL_ADDR_W];
            assign dst_row   = head[gi][PCKT_DATA_W +: PCKT_ROW_ADDR_W];
            assign req[gi]   = route;
            assign ovf[gi]   = ovf_q;

            // X is resolved before Y; an empty FIFO requests nothing
            always_comb begin
                route = '0;
                if (cnt_q != '0) begin
                    if (dst_col > PCKT_COL_ADDR_W'(COL_CORD))      route[P_EST] = 1'b1;
                    else if (dst_col < PCKT_COL_ADDR_W'(COL_CORD)) route[P_WST] = 1'b1;
                    else if (dst_row > PCKT_ROW_ADDR_W'(ROW_CORD)) route[P_STH] = 1'b1;
                    else if (dst_row < PCKT_ROW_ADDR_W'(ROW_CORD)) route[P_NTH] = 1'b1;
                    else                                           route[P_RES] = 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push && !rst_i) mem_q[wr_ptr_q] <= bus.pckt_sw_i[gi*PCKT_W +: PCKT_W];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    ovf_q    <= 1'b0;
                end else begin
                    if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
                    cnt_q <= cnt_d;
                    ovf_q <= bus.wr_en_sw_i[gi] && full[gi];
                end
            end
        end
    endgenerate

    // Each head requests exactly one output, so an input can never win twice per cycle.
    always_comb begin
        pop      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int o = 0; o < PORT_N; o++) begin
            grant_vld[o]  = 1'b0;
            grant_idx[o]  = '0;
            grant_pckt[o] = '0;
            if (!bus.nxt_fifo_full_i[o]) begin
                for (int k = 0; k < PORT_N; k++) begin
                    cand     = (int'(rr_ptr[o]) + k) % PORT_N;
                    cand_idx = IDX_W'(cand);
                    if (!grant_vld[o] && req[cand_idx][o]) begin
                        grant_vld[o]  = 1'b1;
                        grant_idx[o]  = cand_idx;
                        grant_pckt[o] = head[cand_idx];
                        pop[cand_idx] = 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (gi = 0; gi < PORT_N; gi++) begin : g_out
            logic [IDX_W-1:0]  ptr_q, ptr_d;
            logic              wr_en_q;
            logic [PCKT_W-1:0] pckt_q;

            assign ptr_d = (grant_idx[gi] == IDX_W'(PORT_N - 1)) ? '0 : grant_idx[gi] + 1'b1;
            assign rr_ptr[gi] = ptr_q;
            assign bus.wr_en_sw_o[gi] = wr_en_q;
            assign bus.pckt_sw_o[gi*PCKT_W +: PCKT_W] = pckt_q;

            // payload holds between grants; only the strobe drops
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    ptr_q   <= '0;
                    wr_en_q <= 1'b0;
                    pckt_q  <= '0;
                end else begin
                    wr_en_q <= grant_vld[gi];
                    if (grant_vld[gi]) begin
                        pckt_q <= grant_pckt[gi];
                        ptr_q  <= ptr_d;
                    end
                end
            end
        end
    endgenerate

    assign bus.in_fifo_full_o     = full;
    assign bus.in_fifo_overflow_o = ovf;
endmodule

// File: tb/tb_xy_router_rr.sv
// Bench for the XY router at node (1,1): queue-based reference model feeds a per-output
// scoreboard that a negedge monitor drains, plus directed checks for the named scenarios.
`timescale 1ns/1ps
module tb_xy_router_rr;
    localparam int PN    = 5;
    localparam int PW    = 16;
    localparam int COL   = 1;
    localparam int ROW   = 1;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xy_router_rr_if #(.PORT_N(PN), .PCKT_W(PW)) bus ();

    xy_router_rr #(
        .COL_CORD(COL), .ROW_CORD(ROW), .PORT_N(PN), .IN_FIFO_DEPTH_W(3),
        .PCKT_COL_ADDR_W(4), .PCKT_ROW_ADDR_W(4), .PCKT_DATA_W(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] mq  [PN][$];
    logic [PW-1:0] sbq [PN][$];
    int            mptr  [PN];
    int            pre   [PN];
    bit            taken [PN];
    int            m_i;
    logic [PN-1:0] exp_wr   = '0;
    logic [PN-1:0] exp_full = '0;
    logic [PN-1:0] exp_ovf  = '0;
    int            cyc = 0;

    int            n_out   [PN];
    int            ovf_cnt [PN];
    bit            log_on = 1'b0;
    logic [7:0]    log_d [$];
    int            log_c [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    function automatic int route(input logic [PW-1:0] pk);
        int dc = int'(pk[15:12]);
        int dr = int'(pk[11:8]);
        if (dc > COL) return 2;
        if (dc < COL) return 4;
        if (dr > ROW) return 3;
        if (dr < ROW) return 1;
        return 0;
    endfunction

    // Reference model: FIFOs are plain queues, arbitration is a linear scan from the pointer.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int p = 0; p < PN; p++) begin
                mq[p].delete();
                sbq[p].delete();
                mptr[p] = 0;
            end
            exp_wr   = '0;
            exp_ovf  = '0;
            exp_full = '0;
        end else begin
            for (int p = 0; p < PN; p++) begin
                pre[p]   = mq[p].size();
                taken[p] = 1'b0;
            end
            exp_wr = '0;
            for (int o = 0; o < PN; o++) begin
                if (!bus.nxt_fifo_full_i[o]) begin
                    for (int k = 0; k < PN; k++) begin
                        m_i = (mptr[o] + k) % PN;
                        if (!exp_wr[o] && !taken[m_i] && pre[m_i] > 0 && route(mq[m_i][0]) == o) begin
                            exp_wr[o]  = 1'b1;
                            taken[m_i] = 1'b1;
                            sbq[o].push_back(mq[m_i].pop_front());
                            mptr[o] = (m_i + 1) % PN;
                        end
                    end
                end
            end
            for (int p = 0; p < PN; p++) begin
                exp_ovf[p] = 1'b0;
                if (bus.wr_en_sw_i[p]) begin
                    if (pre[p] >= DEPTH) exp_ovf[p] = 1'b1;
                    else mq[p].push_back(bus.pckt_sw_i[p*PW +: PW]);
                end
                exp_full[p] = (mq[p].size() == DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        logic [PW-1:0] e;
        chk("wr_en_sw_o", bus.wr_en_sw_o, exp_wr);
        chk("in_fifo_full_o", bus.in_fifo_full_o, exp_full);
        chk("in_fifo_overflow_o", bus.in_fifo_overflow_o, exp_ovf);
        for (int o = 0; o < PN; o++) begin
            if (bus.wr_en_sw_o[o] === 1'b1) begin
                n_out[o]++;
                if (sbq[o].size() == 0) begin
                    fail_now($sformatf("pckt_o%0d", o), "unexpected packet, scoreboard empty");
                end else begin
                    e = sbq[o].pop_front();
                    chk($sformatf("pckt_o%0d", o), bus.pckt_sw_o[o*PW +: PW], e);
                end
                if (o == 0 && log_on) begin
                    log_d.push_back(bus.pckt_sw_o[7:0]);
                    log_c.push_back(cyc);
                end
            end
            if (bus.in_fifo_overflow_o[o] === 1'b1) ovf_cnt[o]++;
        end
    end

    function automatic logic [PW-1:0] mk(input int c, input int r, input int d);
        return {4'(c), 4'(r), 8'(d)};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic put(input int p, input logic [PW-1:0] pk);
        bus.wr_en_sw_i[p]            = 1'b1;
        bus.pckt_sw_i[p*PW +: PW]    = pk;
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < PN; p++)
            if (mq[p].size() != 0 || sbq[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        int t = 0;
        while (t < 300 && !all_empty()) begin
            step();
            t++;
        end
        if (!all_empty()) fail_now("drain_timeout", "packets still pending after 300 cycles");
        step(2);
    endtask

    task automatic clear_counts();
        for (int p = 0; p < PN; p++) begin
            n_out[p]   = 0;
            ovf_cnt[p] = 0;
        end
    endtask

    task automatic single(input int c, input int r, input int d, input int port);
        logic [PN-1:0] want;
        want = PN'(1 << port);
        put(0, mk(c, r, d));
        step();
        bus.wr_en_sw_i = '0;
        chk($sformatf("latency_early_%0d", port), bus.wr_en_sw_o, 5'b0);
        step();
        chk($sformatf("route_to_%0d", port), bus.wr_en_sw_o, want);
        chk($sformatf("payload_%0d", port), bus.pckt_sw_o[port*PW +: PW], mk(c, r, d));
        step(2);
    endtask

    initial begin
        logic [7:0] ld;
        int         tot;
        bus.wr_en_sw_i      = '0;
        bus.pckt_sw_i       = '0;
        bus.nxt_fifo_full_i = '0;
        clear_counts();
        rst = 1'b1;
        step(2);
        chk("reset_pckt_sw_o", bus.pckt_sw_o, '0);
        chk("reset_wr_en", bus.wr_en_sw_o, '0);
        chk("reset_full", bus.in_fifo_full_o, '0);
        chk("reset_ovf", bus.in_fifo_overflow_o, '0);
        rst = 1'b0;
        step();

        single(2, 1, 'hA5, 2);
        single(1, 1, 'h11, 0);
        single(1, 0, 'h22, 1);
        single(0, 1, 'h33, 4);
        single(1, 2, 'h44, 3);

        // fairness: ports 1..3 each queue 4 packets for RESOURCE while it is blocked
        bus.nxt_fifo_full_i = 5'b00001;
        for (int s = 0; s < 4; s++) begin
            for (int p = 1; p <= 3; p++) put(p, mk(1, 1, p*16 + s));
            step();
        end
        bus.wr_en_sw_i = '0;
        log_d.delete();
        log_c.delete();
        log_on = 1'b1;
        bus.nxt_fifo_full_i = '0;
        drain();
        log_on = 1'b0;
        chk("fair_count", log_d.size(), 12);
        for (int j = 0; j < log_d.size(); j++) begin
            ld = log_d[j];
            chk($sformatf("fair_order_%0d", j), ld[7:4], (j % 3) + 1);
            if (j > 0) chk($sformatf("fair_nogap_%0d", j), log_c[j] - log_c[j-1], 1);
        end

        // back-pressure on EAST
        clear_counts();
        bus.nxt_fifo_full_i = 5'b00100;
        for (int s = 0; s < 4; s++) begin
            put(0, mk(3, s, 'h30 + s));
            put(4, mk(2, 0, 'h40 + s));
            step();
        end
        bus.wr_en_sw_i = '0;
        step(5);
        chk("bp_no_output", n_out[2], 0);
        bus.nxt_fifo_full_i = '0;
        drain();
        chk("bp_delivered", n_out[2], 8);

        // overflow on port 0 with RESOURCE blocked
        clear_counts();
        bus.nxt_fifo_full_i = 5'b00001;
        for (int s = 0; s < 9; s++) begin
            put(0, mk(1, 1, 'h80 + s));
            step();
            if (s == 6) chk("ovf_not_full_at_7", bus.in_fifo_full_o[0], 1'b0);
            if (s == 7) chk("ovf_full_at_8", bus.in_fifo_full_o[0], 1'b1);
            if (s == 8) chk("ovf_pulse_9th", bus.in_fifo_overflow_o[0], 1'b1);
        end
        bus.wr_en_sw_i = '0;
        step();
        chk("ovf_pulse_ends", bus.in_fifo_overflow_o[0], 1'b0);
        bus.nxt_fifo_full_i = '0;
        drain();
        chk("ovf_pulse_count", ovf_cnt[0], 1);
        chk("ovf_delivered", n_out[0], 8);

        // reset with traffic buffered
        bus.nxt_fifo_full_i = 5'b11111;
        put(0, mk(2, 2, 1));
        put(1, mk(0, 0, 2));
        put(3, mk(1, 1, 3));
        step();
        bus.wr_en_sw_i = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.nxt_fifo_full_i = '0;
        clear_counts();
        step(10);
        tot = 0;
        for (int p = 0; p < PN; p++) tot += n_out[p];
        chk("rst_no_output", tot, 0);
        chk("rst_full_clear", bus.in_fifo_full_o, '0);
        chk("rst_pckt_zero", bus.pckt_sw_o, '0);

        // randomized traffic with random back-pressure
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < PN; p++) begin
                if ($urandom_range(0, 99) < 30)
                    put(p, mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 255)));
                else
                    bus.wr_en_sw_i[p] = 1'b0;
                bus.nxt_fifo_full_i[p] = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        bus.wr_en_sw_i      = '0;
        bus.nxt_fifo_full_i = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
